// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_ctrl_pkg: shared FSM state encoding and default constants for the CPU clock-enable generator.
// No ports; imported by cpu_clk_ctrl, clk_prescaler and the bench.
package cpu_clk_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;
    localparam int DIV_INIT_DEF = 63;
    localparam int STEP_W_DEF   = 16;
endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: control/status bundle between the top-level controller and the clock-enable generator.
// Signals: div_load/div_in (divisor load), cmd_run/cmd_halt/cmd_step/step_count (mode commands),
//          tick/cpu_clk/running/step_done (generator outputs).
// With CPU_CLK_CTRL_STATS_EN defined it also carries stats_clr (in) and tick_total[31:0] (out).
// master = the controlling side, slave = cpu_clk_ctrl.
interface cpu_clk_ctrl_if #(
    parameter int DIV_W  = 8,
    parameter int STEP_W = 16
);
    logic              div_load;
    logic [DIV_W-1:0]  div_in;
    logic              cmd_run;
    logic              cmd_halt;
    logic              cmd_step;
    logic [STEP_W-1:0] step_count;
    logic              tick;
    logic              cpu_clk;
    logic              running;
    logic              step_done;
`ifdef CPU_CLK_CTRL_STATS_EN
    logic              stats_clr;
    logic [31:0]       tick_total;
    modport master (output div_load, div_in, cmd_run, cmd_halt, cmd_step, step_count, stats_clr,
                    input  tick, cpu_clk, running, step_done, tick_total);
    modport slave  (input  div_load, div_in, cmd_run, cmd_halt, cmd_step, step_count, stats_clr,
                    output tick, cpu_clk, running, step_done, tick_total);
`else
    modport master (output div_load, div_in, cmd_run, cmd_halt, cmd_step, step_count,
                    input  tick, cpu_clk, running, step_done);
    modport slave  (input  div_load, div_in, cmd_run, cmd_halt, cmd_step, step_count,
                    output tick, cpu_clk, running, step_done);
`endif
endinterface

// File: rtl/cpu_clk_ctrl_clk_prescaler.sv
// clk_prescaler: programmable divisor register plus wrap-at-divisor counter producing a hit strobe.
// Ports: clk, rst (sync, active-high), load (latch div_in and restart count), div_in[DIV_W],
//        hit (combinational, high in the cycle the counter sits at the divisor; suppressed while loading).
module clk_prescaler
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             hit
);
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    // >= rather than == keeps the counter bounded even if it were ever above the divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(DIV_INIT);
            cnt   <= '0;
        end else if (load) begin
            div_q <= div_in;
            cnt   <= '0;
        end else begin
            cnt <= (cnt >= div_q) ? '0 : cnt + 1'b1;
        end
    end
    assign hit = !load && (cnt >= div_q);
endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: CPU clock-enable generator with programmable divisor and RUN/HALT/STEP modes.
// Ports: clk, rst (sync, active-high), bus (cpu_clk_ctrl_if.slave): div_load/div_in, cmd_run/cmd_halt/cmd_step,
//        step_count in; tick (1-cycle enable), cpu_clk (toggles per tick), running, step_done out.
// Optional: define CPU_CLK_CTRL_STATS_EN to add stats_clr in and tick_total[31:0] out (ticks since reset, wrapping).
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = DIV_INIT_DEF,
    parameter int STEP_W   = STEP_W_DEF,
    parameter bit RUN_INIT = 1'b1
) (
    input logic           clk,
    input logic           rst,
    cpu_clk_ctrl_if.slave bus
);
    state_e            state, state_nxt;
    logic [STEP_W-1:0] remaining, remaining_nxt, step_load;
    logic              hit, last_step, tick_q, tick_nxt, clk_q, done_q, done_nxt;
    clk_prescaler #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .load   (bus.div_load),
        .div_in (bus.div_in),
        .hit    (hit)
    );
    assign step_load = (bus.step_count == '0) ? STEP_W'(1) : bus.step_count;
    // The final step tick is on the wire now: no further tick may be scheduled behind it
    assign last_step = (state == ST_STEP) && tick_q && (remaining == STEP_W'(1));
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        if (bus.cmd_halt) begin
            state_nxt = ST_HALT;
        end else if (bus.cmd_run) begin
            state_nxt = ST_RUN;
        end else if (bus.cmd_step) begin
            state_nxt     = ST_STEP;
            remaining_nxt = step_load;
        end else if (state == ST_STEP && tick_q) begin
            remaining_nxt = (remaining == '0) ? '0 : remaining - 1'b1;
            state_nxt     = last_step ? ST_HALT : ST_STEP;
            done_nxt      = last_step;
        end
        tick_nxt = hit && ((state == ST_RUN) || (state == ST_STEP && !last_step));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN_INIT ? ST_RUN : ST_HALT;
            remaining <= '0;
            tick_q    <= 1'b0;
            clk_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            tick_q    <= tick_nxt;
            clk_q     <= clk_q ^ tick_q;
            done_q    <= done_nxt;
        end
    end
    assign bus.tick      = tick_q;
    assign bus.cpu_clk   = clk_q;
    assign bus.step_done = done_q;
    assign bus.running   = (state != ST_HALT);
`ifdef CPU_CLK_CTRL_STATS_EN
    logic [31:0] tick_total;
    // A clear wins over a coincident tick
    always_ff @(posedge clk) begin
        if (rst || bus.stats_clr) tick_total <= '0;
        else if (tick_q) tick_total <= tick_total + 32'd1;
    end
    assign bus.tick_total = tick_total;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: scoreboard bench for cpu_clk_ctrl; a timing-rule model predicts each cycle's outputs.
module tb_cpu_clk_ctrl;
    import cpu_clk_ctrl_pkg::*;
    typedef struct packed {
        logic        tick;
        logic        cclk;
        logic        run;
        logic        done;
        logic [31:0] total;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_v = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int dut_ticks = 0;
    int dut_dones = 0;
    exp_t q[$];
    // model: mode 0=halted 1=running 2=stepping; ticks fall at cycles org + k*(div+1) + div + 1
    int m_mode = 1, m_left = 0, m_div = 63, m_org = 0, m_cyc = 0;
    bit m_tick = 0, m_clk = 0, m_done = 0;
    int unsigned m_total = 0;
    cpu_clk_ctrl_if #(.DIV_W(8), .STEP_W(16)) bus ();
    cpu_clk_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef CPU_CLK_CTRL_STATS_EN
    assign bus.stats_clr = clr_v;
`endif
    always #5 clk = ~clk;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic model_step();
        bit hit, fin, nt;
        if (rst) begin
            m_mode = 1; m_left = 0; m_tick = 0; m_clk = 0; m_done = 0; m_total = 0;
            m_div = 63; m_org = m_cyc + 1;
        end else begin
            hit = !bus.div_load && ((m_cyc - m_org) % (m_div + 1) == m_div);
            fin = (m_mode == 2) && m_tick && (m_left == 1);
            nt = hit && (m_mode == 1 || (m_mode == 2 && !fin));
            m_clk = m_clk ^ m_tick;
            m_total = clr_v ? 0 : m_total + 32'(m_tick);
            m_done = 0;
            if (bus.cmd_halt) m_mode = 0;
            else if (bus.cmd_run) m_mode = 1;
            else if (bus.cmd_step) begin
                m_mode = 2;
                m_left = (bus.step_count == 0) ? 1 : int'(bus.step_count);
            end else if (m_mode == 2 && m_tick) begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_done = 1; end
            end
            m_tick = nt;
            if (bus.div_load) begin m_div = int'(bus.div_in); m_org = m_cyc + 1; end
        end
        m_cyc++;
        q.push_back({m_tick, m_clk, m_mode != 0, m_done, m_total});
    endtask
    initial forever begin
        @(posedge clk);
        model_step();
    end
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("tick", bus.tick, e.tick);
            chk("cpu_clk", bus.cpu_clk, e.cclk);
            chk("running", bus.running, e.run);
            chk("step_done", bus.step_done, e.done);
`ifdef CPU_CLK_CTRL_STATS_EN
            chk("tick_total", bus.tick_total, e.total);
`endif
            if (bus.tick === 1'b1) dut_ticks++;
            if (bus.step_done === 1'b1) dut_dones++;
        end
    end
    task automatic idle();
        bus.div_load = 0; bus.div_in = 0; bus.cmd_run = 0; bus.cmd_halt = 0;
        bus.cmd_step = 0; bus.step_count = 0; clr_v = 0; rst = 0;
    endtask
    task automatic drive(bit ld, int din, bit r, bit h, bit s, int sc, bit c, bit rs);
        bus.div_load = ld; bus.div_in = 8'(din); bus.cmd_run = r; bus.cmd_halt = h;
        bus.cmd_step = s; bus.step_count = 16'(sc); rst = rs;
`ifdef CPU_CLK_CTRL_STATS_EN
        clr_v = c;
`else
        clr_v = 1'b0 & c;
`endif
        @(posedge clk); #1;
        idle();
    endtask
    task automatic wait_n(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        int t0, d0, k;
        idle();
        rst = 1;
        wait_n(3);
        rst = 0;
        chk("reset_running", bus.running, 1);
        chk("reset_cpu_clk", bus.cpu_clk, 0);
        wait_n(300);
        // divisor 0 then 3
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        wait_n(20);
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        wait_n(30);
        // 5-step burst from HALT
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        wait_n(10);
        t0 = dut_ticks; d0 = dut_dones;
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        wait_n(40);
        chk("step5_ticks", dut_ticks - t0, 5);
        chk("step5_done", dut_dones - d0, 1);
        chk("step5_running", bus.running, 0);
        // step_count 0 behaves as 1
        t0 = dut_ticks; d0 = dut_dones;
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        wait_n(15);
        chk("step0_ticks", dut_ticks - t0, 1);
        chk("step0_done", dut_dones - d0, 1);
        // halt beats run
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        wait_n(5);
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        wait_n(10);
        chk("halt_wins", bus.running, 0);
        // reset in the middle of a 10-step burst
        t0 = dut_ticks; d0 = dut_dones;
        drive(0, 0, 0, 0, 1, 10, 0, 0);
        k = 0;
        while (dut_ticks - t0 < 2 && k < 200) begin @(negedge clk); k++; end
        chk("step10_reached_2", (k < 200) ? 1 : 0, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_cpu_clk", bus.cpu_clk, 0);
        wait_n(300);
        chk("rst_no_done", dut_dones - d0, 0);
`ifdef CPU_CLK_CTRL_STATS_EN
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        wait_n(5);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        d0 = dut_dones;
        drive(0, 0, 0, 0, 1, 100, 0, 0);
        k = 0;
        while (dut_dones == d0 && k < 400) begin @(negedge clk); k++; end
        chk("stats_100", bus.tick_total, 100);
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        wait_n(5);
        chk("stats_tick_live", bus.tick, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("stats_clr_tick", bus.tick_total, 0);
        @(posedge clk); #1;
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 29) == 0, $urandom_range(0, 5),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 5),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 499) == 0);
        end
        wait_n(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
